mau_tbl_upd_seq: RTL and testbench

Table-update sequencer for one `mau_stage`. It takes entry add/modify/delete requests from two requesters, arbitrates between them round-robin, and drives the stage's `mau_cfg_if` TCAM and Action-SRAM write ports. Every update is a fixed, ordered sequence of single-cycle write pulses, so a live lookup never pairs a new key with a stale action. Requester 0 is the TUE control-plane path; requester 1 is the learn/aging engine.

---
 rtl/mau_tbl_upd_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_mau_tbl_upd_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mau_tbl_upd_seq.sv
// Table-update sequencer: round-robin arbitration between two requesters, then a fixed
// ordered sequence of TCAM/ASRAM write pulses. Optional feature macro: MAU_UPD_HITLESS_EN.
module mau_tbl_upd_seq #(
    parameter int KEY_W    = 512,
    parameter int TCAM_AW  = 11,
    parameter int ASRAM_AW = 16,
    parameter int ASRAM_W  = 128
) (
    input  logic                           clk_dp,
    input  logic                           rst_dp_n,
    input  logic [1:0]                     req_valid_i,
    output logic [1:0]                     req_ready_o,
    input  logic [1:0]                     req_op_i,
    input  logic [1:0][TCAM_AW-1:0]        req_addr_i,
    input  logic [1:0][KEY_W-1:0]          req_key_i,
    input  logic [1:0][KEY_W-1:0]          req_mask_i,
    input  logic [1:0][15:0]               req_action_id_i,
    input  logic [1:0][15:0]               req_action_ptr_i,
    input  logic [1:0][ASRAM_W-1:0]        req_asram_data_i,
    output logic                           tcam_wr_en_o,
    output logic [TCAM_AW-1:0]             tcam_wr_addr_o,
    output logic [KEY_W-1:0]               tcam_wr_key_o,
    output logic [KEY_W-1:0]               tcam_wr_mask_o,
    output logic [15:0]                    tcam_action_id_o,
    output logic [15:0]                    tcam_action_ptr_o,
    output logic                           tcam_wr_valid_o,
    output logic                           asram_wr_en_o,
    output logic [ASRAM_AW-1:0]            asram_wr_addr_o,
    output logic [ASRAM_W-1:0]             asram_wr_data_o,
    output logic                           done_valid_o,
    output logic                           done_port_o,
    output logic                           busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INVAL  = 3'd1,
        ST_ASRAM  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 grant_s;
    logic                 accept_s;

    logic                 hold_op_q, hold_op_d;
    logic                 hold_port_q, hold_port_d;
    logic [TCAM_AW-1:0]   hold_addr_q, hold_addr_d;
    logic [KEY_W-1:0]     hold_key_q, hold_key_d;
    logic [KEY_W-1:0]     hold_mask_q, hold_mask_d;
    logic [15:0]          hold_id_q, hold_id_d;
    logic [15:0]          hold_ptr_q, hold_ptr_d;
    logic [ASRAM_W-1:0]   hold_data_q, hold_data_d;

    logic                 tcam_wr_en_d, tcam_wr_valid_d, asram_wr_en_d;
    logic                 done_valid_d, done_port_d;
    logic [TCAM_AW-1:0]   tcam_wr_addr_d;
    logic [KEY_W-1:0]     tcam_wr_key_d, tcam_wr_mask_d;
    logic [15:0]          tcam_action_id_d, tcam_action_ptr_d;
    logic [ASRAM_AW-1:0]  asram_wr_addr_d;
    logic [ASRAM_W-1:0]   asram_wr_data_d;

    // Round-robin grant: a tie goes to the port that did not win last time.
    always_comb begin
        grant_s = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (req_valid_i[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign accept_s = (state_q == ST_IDLE) && req_valid_i[grant_s];

    // Ready is asserted only toward the granted port while idle.
    always_comb begin
        req_ready_o = 2'b00;
        if (accept_s) begin
            req_ready_o[grant_s] = 1'b1;
        end else begin
            req_ready_o = 2'b00;
        end
    end

    // Holding register and arbitration pointer next-state.
    always_comb begin
        last_grant_d = last_grant_q;
        hold_op_d    = hold_op_q;
        hold_port_d  = hold_port_q;
        hold_addr_d  = hold_addr_q;
        hold_key_d   = hold_key_q;
        hold_mask_d  = hold_mask_q;
        hold_id_d    = hold_id_q;
        hold_ptr_d   = hold_ptr_q;
        hold_data_d  = hold_data_q;
        if (accept_s) begin
            last_grant_d = grant_s;
            hold_op_d    = req_op_i[grant_s];
            hold_port_d  = grant_s;
            hold_addr_d  = req_addr_i[grant_s];
            hold_key_d   = req_key_i[grant_s];
            hold_mask_d  = req_mask_i[grant_s];
            hold_id_d    = req_action_id_i[grant_s];
            hold_ptr_d   = req_action_ptr_i[grant_s];
            hold_data_d  = req_asram_data_i[grant_s];
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Sequencer next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef MAU_UPD_HITLESS_EN
                    state_d = ST_INVAL;
`else
                    state_d = req_op_i[grant_s] ? ST_INVAL : ST_ASRAM;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INVAL:  state_d = hold_op_q ? ST_DONE : ST_ASRAM;
            ST_ASRAM:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded from the next state so each pulse lines up with its state.
    always_comb begin
        tcam_wr_en_d      = (state_d == ST_INVAL) || (state_d == ST_COMMIT);
        tcam_wr_valid_d   = (state_d == ST_COMMIT);
        asram_wr_en_d     = (state_d == ST_ASRAM);
        done_valid_d      = (state_d == ST_DONE);
        done_port_d       = done_port_o;
        tcam_wr_addr_d    = tcam_wr_addr_o;
        tcam_wr_key_d     = tcam_wr_key_o;
        tcam_wr_mask_d    = tcam_wr_mask_o;
        tcam_action_id_d  = tcam_action_id_o;
        tcam_action_ptr_d = tcam_action_ptr_o;
        asram_wr_addr_d   = asram_wr_addr_o;
        asram_wr_data_d   = asram_wr_data_o;
        if (tcam_wr_en_d) begin
            tcam_wr_addr_d    = hold_addr_d;
            tcam_wr_key_d     = hold_key_d;
            tcam_wr_mask_d    = hold_mask_d;
            tcam_action_id_d  = hold_id_d;
            tcam_action_ptr_d = hold_ptr_d;
        end else begin
            tcam_wr_addr_d    = tcam_wr_addr_o;
        end
        if (asram_wr_en_d) begin
            asram_wr_addr_d = hold_ptr_d[ASRAM_AW-1:0];
            asram_wr_data_d = hold_data_d;
        end else begin
            asram_wr_addr_d = asram_wr_addr_o;
        end
        if (done_valid_d) begin
            done_port_d = hold_port_d;
        end else begin
            done_port_d = done_port_o;
        end
    end

    // State, arbitration pointer and holding register.
    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            hold_op_q    <= 1'b0;
            hold_port_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_key_q   <= '0;
            hold_mask_q  <= '0;
            hold_id_q    <= 16'h0000;
            hold_ptr_q   <= 16'h0000;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_op_q    <= hold_op_d;
            hold_port_q  <= hold_port_d;
            hold_addr_q  <= hold_addr_d;
            hold_key_q   <= hold_key_d;
            hold_mask_q  <= hold_mask_d;
            hold_id_q    <= hold_id_d;
            hold_ptr_q   <= hold_ptr_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // Registered write-port and completion outputs.
    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            tcam_wr_en_o      <= 1'b0;
            tcam_wr_valid_o   <= 1'b0;
            asram_wr_en_o     <= 1'b0;
            done_valid_o      <= 1'b0;
            done_port_o       <= 1'b0;
            tcam_wr_addr_o    <= '0;
            tcam_wr_key_o     <= '0;
            tcam_wr_mask_o    <= '0;
            tcam_action_id_o  <= 16'h0000;
            tcam_action_ptr_o <= 16'h0000;
            asram_wr_addr_o   <= '0;
            asram_wr_data_o   <= '0;
        end else begin
            tcam_wr_en_o      <= tcam_wr_en_d;
            tcam_wr_valid_o   <= tcam_wr_valid_d;
            asram_wr_en_o     <= asram_wr_en_d;
            done_valid_o      <= done_valid_d;
            done_port_o       <= done_port_d;
            tcam_wr_addr_o    <= tcam_wr_addr_d;
            tcam_wr_key_o     <= tcam_wr_key_d;
            tcam_wr_mask_o    <= tcam_wr_mask_d;
            tcam_action_id_o  <= tcam_action_id_d;
            tcam_action_ptr_o <= tcam_action_ptr_d;
            asram_wr_addr_o   <= asram_wr_addr_d;
            asram_wr_data_o   <= asram_wr_data_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mau_tbl_upd_seq.sv
// Directed self-checking bench for mau_tbl_upd_seq; expectations follow MAU_UPD_HITLESS_EN.
module tb_mau_tbl_upd_seq;

    logic                 clk_dp = 1'b0;
    logic                 rst_dp_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op;
    logic [1:0][10:0]     req_addr;
    logic [1:0][511:0]    req_key;
    logic [1:0][511:0]    req_mask;
    logic [1:0][15:0]     req_action_id;
    logic [1:0][15:0]     req_action_ptr;
    logic [1:0][127:0]    req_asram_data;
    logic                 tcam_wr_en, tcam_wr_valid, asram_wr_en;
    logic [10:0]          tcam_wr_addr;
    logic [511:0]         tcam_wr_key, tcam_wr_mask;
    logic [15:0]          tcam_action_id, tcam_action_ptr;
    logic [15:0]          asram_wr_addr;
    logic [127:0]         asram_wr_data;
    logic                 done_valid, done_port, busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [511:0] KEY_A  = {16{32'hDEADBEEF}};
    localparam logic [511:0] MASK_A = {16{32'hFFFF0000}};
    localparam logic [127:0] DATA_A = {16{8'hAB}};

    mau_tbl_upd_seq dut (
        .clk_dp            (clk_dp),
        .rst_dp_n          (rst_dp_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_addr_i        (req_addr),
        .req_key_i         (req_key),
        .req_mask_i        (req_mask),
        .req_action_id_i   (req_action_id),
        .req_action_ptr_i  (req_action_ptr),
        .req_asram_data_i  (req_asram_data),
        .tcam_wr_en_o      (tcam_wr_en),
        .tcam_wr_addr_o    (tcam_wr_addr),
        .tcam_wr_key_o     (tcam_wr_key),
        .tcam_wr_mask_o    (tcam_wr_mask),
        .tcam_action_id_o  (tcam_action_id),
        .tcam_action_ptr_o (tcam_action_ptr),
        .tcam_wr_valid_o   (tcam_wr_valid),
        .asram_wr_en_o     (asram_wr_en),
        .asram_wr_addr_o   (asram_wr_addr),
        .asram_wr_data_o   (asram_wr_data),
        .done_valid_o      (done_valid),
        .done_port_o       (done_port),
        .busy_o            (busy)
    );

    always #5 clk_dp = ~clk_dp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_dp);
        #1;
    endtask

    initial begin
        int idx;
        int seen;
        logic port_seen;

        rst_dp_n       = 1'b0;
        req_valid      = 2'b00;
        req_op         = 2'b00;
        req_addr       = '0;
        req_key        = '0;
        req_mask       = '0;
        req_action_id  = '0;
        req_action_ptr = '0;
        req_asram_data = '0;
        repeat (3) tick();
        rst_dp_n = 1'b1;
        repeat (10) tick();

        // Idle after reset.
        chk("rst_tcam_en",    128'(tcam_wr_en),    128'(0));
        chk("rst_tcam_valid", 128'(tcam_wr_valid), 128'(0));
        chk("rst_asram_en",   128'(asram_wr_en),   128'(0));
        chk("rst_done",       128'(done_valid),    128'(0));
        chk("rst_busy",       128'(busy),          128'(0));
        chk("rst_ready",      128'(req_ready),     128'(0));
        chk("rst_tcam_addr",  128'(tcam_wr_addr),  128'(0));
        chk("rst_asram_addr", 128'(asram_wr_addr), 128'(0));
        chk("rst_asram_data", asram_wr_data,       128'(0));
        chk_key("rst_tcam_key", tcam_wr_key,       512'(0));

        // Port 0 ADD.
        req_op[0]         = 1'b0;
        req_addr[0]       = 11'h005;
        req_key[0]        = KEY_A;
        req_mask[0]       = MASK_A;
        req_action_id[0]  = 16'h00A5;
        req_action_ptr[0] = 16'h0123;
        req_asram_data[0] = DATA_A;
        req_valid         = 2'b01;
        #1;
        chk("add_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid         = 2'b00;
        req_addr[0]       = 11'h3FF;
        req_key[0]        = 512'(0);
        req_action_ptr[0] = 16'hFFFF;
        req_asram_data[0] = 128'(0);
`ifdef MAU_UPD_HITLESS_EN
        chk("add_inval_en",    128'(tcam_wr_en),    128'(1));
        chk("add_inval_valid", 128'(tcam_wr_valid), 128'(0));
        chk("add_inval_addr",  128'(tcam_wr_addr),  128'(11'h005));
        chk("add_inval_asram", 128'(asram_wr_en),   128'(0));
        chk("add_inval_ready", 128'(req_ready),     128'(0));
        tick();
`endif
        chk("add_asram_en",   128'(asram_wr_en),   128'(1));
        chk("add_asram_addr", 128'(asram_wr_addr), 128'(16'h0123));
        chk("add_asram_data", asram_wr_data,       DATA_A);
        chk("add_asram_tcam", 128'(tcam_wr_en),    128'(0));
        chk("add_asram_busy", 128'(busy),          128'(1));
        tick();
        chk("add_commit_en",    128'(tcam_wr_en),      128'(1));
        chk("add_commit_valid", 128'(tcam_wr_valid),   128'(1));
        chk("add_commit_addr",  128'(tcam_wr_addr),    128'(11'h005));
        chk("add_commit_id",    128'(tcam_action_id),  128'(16'h00A5));
        chk("add_commit_ptr",   128'(tcam_action_ptr), 128'(16'h0123));
        chk("add_commit_asram", 128'(asram_wr_en),     128'(0));
        chk_key("add_commit_key",  tcam_wr_key,  KEY_A);
        chk_key("add_commit_mask", tcam_wr_mask, MASK_A);
        tick();
        chk("add_done_valid", 128'(done_valid), 128'(1));
        chk("add_done_port",  128'(done_port),  128'(0));
        chk("add_done_tcam",  128'(tcam_wr_en), 128'(0));
        tick();
        chk("add_after_done", 128'(done_valid), 128'(0));
        chk("add_after_busy", 128'(busy),       128'(0));

        // Port 1 DELETE.
        req_op[1]         = 1'b1;
        req_addr[1]       = 11'h7FF;
        req_action_ptr[1] = 16'h4444;
        req_valid         = 2'b10;
        #1;
        chk("del_ready", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00;
        chk("del_inval_en",    128'(tcam_wr_en),    128'(1));
        chk("del_inval_valid", 128'(tcam_wr_valid), 128'(0));
        chk("del_inval_addr",  128'(tcam_wr_addr),  128'(11'h7FF));
        chk("del_inval_asram", 128'(asram_wr_en),   128'(0));
        tick();
        chk("del_done_valid", 128'(done_valid),  128'(1));
        chk("del_done_port",  128'(done_port),   128'(1));
        chk("del_done_asram", 128'(asram_wr_en), 128'(0));
        tick();
        chk("del_idle_busy", 128'(busy), 128'(0));

        // Both ports request continuously: grants alternate starting at port 0.
        req_op[0]   = 1'b0;
        req_addr[0] = 11'h001;
        req_op[1]   = 1'b1;
        req_addr[1] = 11'h002;
        req_valid   = 2'b11;
        #1;
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
            chk("rr_no_overlap", 128'(tcam_wr_en && asram_wr_en), 128'(0));
            chk("rr_ready_idle", 128'((req_ready != 2'b00) && busy), 128'(0));
            if (req_ready != 2'b00) begin
                chk("rr_grant", 128'(req_ready), ((idx % 2) == 0) ? 128'(2'b01) : 128'(2'b10));
                idx++;
            end
            tick();
        end
        chk("rr_count", 128'(idx), 128'(4));
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 20 && busy; cyc++) begin
            chk("rr_drain_overlap", 128'(tcam_wr_en && asram_wr_en), 128'(0));
            tick();
        end
        chk("rr_drain_busy", 128'(busy), 128'(0));

        // Reset in the ASRAM cycle of an ADD.
        req_op[0]         = 1'b0;
        req_addr[0]       = 11'h010;
        req_action_ptr[0] = 16'h0200;
        req_valid         = 2'b01;
        #1;
        chk("rstmid_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
`ifdef MAU_UPD_HITLESS_EN
        tick();
`endif
        chk("rstmid_asram_en", 128'(asram_wr_en), 128'(1));
        #2;
        rst_dp_n = 1'b0;
        #1;
        chk("rstmid_asram_off", 128'(asram_wr_en),   128'(0));
        chk("rstmid_busy",      128'(busy),          128'(0));
        chk("rstmid_asram_adr", 128'(asram_wr_addr), 128'(0));
        chk("rstmid_tcam_adr",  128'(tcam_wr_addr),  128'(0));
        chk("rstmid_done",      128'(done_valid),    128'(0));
        tick();
        rst_dp_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (done_valid) seen++;
        end
        chk("rstmid_no_done", 128'(seen), 128'(0));

        // Fresh tie after reset goes to port 0 in the first idle cycle.
        req_valid = 2'b11;
        #1;
        chk("post_rst_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        seen      = 0;
        port_seen = 1'b1;
        for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
            if (done_valid) begin
                seen++;
                port_seen = done_port;
            end else begin
                tick();
            end
        end
        chk("post_rst_done", 128'(seen),      128'(1));
        chk("post_rst_port", 128'(port_seen), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
